// File: rtl/sfp_link_ctrl.sv
// sfp_link_ctrl: per-port SFP+ link bring-up FSM (PHY reset, laser enable, lock debounce, retry, fault hold).
// Define SFP_LINK_CTRL_STATS_EN to build the saturating retry_count/drop_count registers.
module sfp_link_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int DEBOUNCE     = 64,
  parameter int FAULT_HOLD   = 156_250,
  parameter int TIMER_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sfp_absent,
  input  logic       sfp_tx_fault,
  input  logic       qplllock,
  input  logic       phy_resetdone,
  input  logic       rx_block_lock,
  input  logic       rx_hi_ber,
  output logic       sfp_tx_disable,
  output logic       phy_rst,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [7:0] drop_count
);
  typedef enum logic [2:0] {
    ST_DISABLED   = 3'd0,
    ST_WAIT_PLL   = 3'd1,
    ST_PHY_RESET  = 3'd2,
    ST_WAIT_LOCK  = 3'd3,
    ST_LINK_UP    = 3'd4,
    ST_FAULT_HOLD = 3'd5
  } state_t;
  state_t cur, nxt;
  logic [TIMER_W-1:0] tmr, tmr_n, deb, deb_n;
  logic abs_s1, abs_s2, flt_s1, flt_s2, good;
  assign good  = phy_resetdone & rx_block_lock & ~rx_hi_ber;
  assign state = cur;
  always_comb begin
    nxt   = cur;
    tmr_n = tmr;
    deb_n = '0;
    if (abs_s2 || cur > ST_FAULT_HOLD) nxt = ST_DISABLED;
    else if (flt_s2 && cur != ST_FAULT_HOLD && cur != ST_DISABLED) begin
      nxt   = ST_FAULT_HOLD;
      tmr_n = TIMER_W'(FAULT_HOLD - 1);
    end else if (!qplllock && (cur == ST_PHY_RESET || cur == ST_WAIT_LOCK || cur == ST_LINK_UP))
      nxt = ST_WAIT_PLL;
    else
      case (cur)
        ST_DISABLED: nxt = ST_WAIT_PLL;
        ST_WAIT_PLL:
          if (qplllock) begin
            nxt   = ST_PHY_RESET;
            tmr_n = TIMER_W'(RST_CYCLES - 1);
          end
        ST_PHY_RESET:
          if (tmr == '0) begin
            nxt   = ST_WAIT_LOCK;
            tmr_n = TIMER_W'(LOCK_TIMEOUT - 1);
          end else tmr_n = tmr - 1'b1;
        ST_WAIT_LOCK: begin
          deb_n = good ? deb + 1'b1 : '0;
          // debounce completion takes precedence over a coincident timeout
          if (deb_n == TIMER_W'(DEBOUNCE)) nxt = ST_LINK_UP;
          else if (tmr == '0) begin
            nxt   = ST_PHY_RESET;
            tmr_n = TIMER_W'(RST_CYCLES - 1);
          end else tmr_n = tmr - 1'b1;
        end
        ST_LINK_UP:
          if (!rx_block_lock || rx_hi_ber) begin
            nxt   = ST_WAIT_LOCK;
            tmr_n = TIMER_W'(LOCK_TIMEOUT - 1);
          end
        ST_FAULT_HOLD:
          if (tmr == '0) begin
            nxt   = flt_s2 ? ST_FAULT_HOLD : ST_WAIT_PLL;
            tmr_n = flt_s2 ? TIMER_W'(FAULT_HOLD - 1) : tmr;
          end else tmr_n = tmr - 1'b1;
        default: nxt = ST_DISABLED;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      abs_s1         <= 1'b1;
      abs_s2         <= 1'b1;
      flt_s1         <= 1'b0;
      flt_s2         <= 1'b0;
      cur            <= ST_DISABLED;
      tmr            <= '0;
      deb            <= '0;
      sfp_tx_disable <= 1'b1;
      phy_rst        <= 1'b1;
      link_up        <= 1'b0;
    end else begin
      abs_s1         <= sfp_absent;
      abs_s2         <= abs_s1;
      flt_s1         <= sfp_tx_fault;
      flt_s2         <= flt_s1;
      cur            <= nxt;
      tmr            <= tmr_n;
      deb            <= deb_n;
      sfp_tx_disable <= !(nxt == ST_WAIT_LOCK || nxt == ST_LINK_UP);
      phy_rst        <= !(nxt == ST_WAIT_LOCK || nxt == ST_LINK_UP);
      link_up        <= nxt == ST_LINK_UP;
    end
`ifdef SFP_LINK_CTRL_STATS_EN
  logic [7:0] retry_q, drop_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retry_q <= '0;
      drop_q  <= '0;
    end else begin
      if (cur == ST_WAIT_LOCK && nxt == ST_PHY_RESET && retry_q != 8'hff) retry_q <= retry_q + 1'b1;
      if (cur == ST_LINK_UP && nxt != ST_LINK_UP && drop_q != 8'hff) drop_q <= drop_q + 1'b1;
    end
  assign retry_count = retry_q;
  assign drop_count  = drop_q;
`else
  assign retry_count = '0;
  assign drop_count  = '0;
`endif
endmodule

// File: tb/tb_sfp_link_ctrl.sv
// tb_sfp_link_ctrl: randomized segments of pin/PCS activity compared every cycle against a behavioural model.
module tb_sfp_link_ctrl;
  localparam int RC = 4, LT = 100, DB = 8, FH = 20;
  logic clk = 1'b0, rst_n;
  logic sfp_absent, sfp_tx_fault, qplllock, phy_resetdone, rx_block_lock, rx_hi_ber;
  logic sfp_tx_disable, phy_rst, link_up;
  logic [2:0] state;
  logic [7:0] retry_count, drop_count;
  int n_checks = 0, n_errors = 0;
  int m_st, m_age, m_run, m_retry, m_drop;
  bit a1, a2, f1, f2;
  sfp_link_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .DEBOUNCE(DB), .FAULT_HOLD(FH), .TIMER_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .sfp_absent(sfp_absent), .sfp_tx_fault(sfp_tx_fault),
    .qplllock(qplllock), .phy_resetdone(phy_resetdone), .rx_block_lock(rx_block_lock),
    .rx_hi_ber(rx_hi_ber), .sfp_tx_disable(sfp_tx_disable), .phy_rst(phy_rst), .link_up(link_up),
    .state(state), .retry_count(retry_count), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_age = 0; m_run = 0; m_retry = 0; m_drop = 0;
    a1 = 1; a2 = 1; f1 = 0; f2 = 0;
  endtask
  // One clock of the spec's rules: age counts cycles spent in the current state (0 on entry)
  task automatic model_step();
    bit good = phy_resetdone && rx_block_lock && !rx_hi_ber;
    int ns = m_st;
    bit restart = 0;
    if (a2) ns = 0;
    else if (f2 && m_st != 5 && m_st != 0) ns = 5;
    else if (!qplllock && m_st >= 2 && m_st <= 4) ns = 1;
    else if (m_st == 0) ns = 1;
    else if (m_st == 1) ns = qplllock ? 2 : 1;
    else if (m_st == 2) ns = (m_age == RC - 1) ? 3 : 2;
    else if (m_st == 3) begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == DB) ns = 4;
      else if (m_age == LT - 1) begin
        ns = 2;
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end else if (m_st == 4) ns = (!rx_block_lock || rx_hi_ber) ? 3 : 4;
    else if (m_st == 5 && m_age == FH - 1) begin
      if (f2) restart = 1;
      else ns = 1;
    end
    if (m_st == 4 && ns != 4) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    if (ns != m_st || restart) begin
      m_age = 0;
      m_run = 0;
    end else m_age++;
    m_st = ns;
    a2 = a1; a1 = sfp_absent;
    f2 = f1; f1 = sfp_tx_fault;
  endtask
  task automatic check_all(input string ph);
    bit on = (m_st == 3 || m_st == 4);
    check({ph, ".state"}, state, m_st);
    check({ph, ".tx_disable"}, sfp_tx_disable, !on);
    check({ph, ".phy_rst"}, phy_rst, !on);
    check({ph, ".link_up"}, link_up, m_st == 4);
`ifdef SFP_LINK_CTRL_STATS_EN
    check({ph, ".retry"}, retry_count, m_retry);
    check({ph, ".drop"}, drop_count, m_drop);
`else
    check({ph, ".retry"}, retry_count, 0);
    check({ph, ".drop"}, drop_count, 0);
`endif
  endtask
  function automatic bit pct(input int p);
    return $urandom_range(999) < p;
  endfunction
  task automatic drive(input int mode);
    phy_resetdone = 1; rx_hi_ber = pct(3); rx_block_lock = !pct(15);
    if (mode != 6) begin
      sfp_absent = (mode == 4) ? sfp_absent ^ pct(20) : 1'b0;
      sfp_tx_fault = (mode == 3) ? sfp_tx_fault ^ pct(30) : 1'b0;
      qplllock = (mode == 5) ? qplllock ^ pct(30) : 1'b1;
    end else begin
      sfp_absent ^= pct(40); sfp_tx_fault ^= pct(40); qplllock ^= pct(40);
    end
    if (mode == 1) rx_block_lock = 0;
    if (mode == 2) begin
      rx_block_lock = !pct(150); rx_hi_ber = pct(50); phy_resetdone = !pct(50);
    end
  endtask
  task automatic run_seg(input int mode, input int len);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all("run");
      drive(mode);
    end
  endtask
  initial begin
    int modes[12] = '{0, 1, 0, 2, 0, 3, 0, 4, 0, 5, 0, 6};
    rst_n = 0; sfp_absent = 1; sfp_tx_fault = 0; qplllock = 0;
    phy_resetdone = 0; rx_block_lock = 0; rx_hi_ber = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1;
    drive(0);
    for (int s = 0; s < 12; s++) run_seg(modes[s], (modes[s] == 1) ? 300 : 200);
    for (int s = 0; s < 16; s++) begin
      run_seg($urandom_range(6), $urandom_range(100, 400));
      if (s == 7) begin
        #2 rst_n = 0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        run_seg(0, 200);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
